quad_encoder_gen: RTL and testbench



---
 rtl/quad_gen_pkg.sv | 17 +
 rtl/quad_period_timer.sv | 33 +++
 rtl/quad_encoder_gen.sv | 133 +++++++++++++
 tb/tb_quad_encoder_gen.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_gen_pkg.sv
// Shared types and constants for the quadrature encoder generator.
// Phase-to-level table and direction codes live here so every user agrees on them.
package quad_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FINISH
   } state_t;

   localparam logic DIR_CW  = 1'b0;
   localparam logic DIR_CCW = 1'b1;

   // {A,B} level per phase index; index 0 is the rest state, one bit flips per step.
   localparam logic [3:0][1:0] AB_LUT = {2'b01, 2'b11, 2'b10, 2'b00};

endpackage

// File: rtl/quad_period_timer.sv
// Reload-on-zero down-counter that paces quadrature edges.
// tick is high in every enabled cycle whose count is zero; the counter then reloads.
module quad_period_timer #(
   parameter int PER_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [PER_W-1:0] load_value,
   input  logic             enable,
   output logic             tick
);

   logic [PER_W-1:0] r_count;
   logic [PER_W-1:0] r_reload;

   assign tick = enable && (r_count == '0);

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_count  <= '0;
         r_reload <= '0;
      end else if (load) begin
         r_count  <= load_value;
         r_reload <= load_value;
      end else if (enable) begin
         if (r_count == '0) r_count <= r_reload;
         else               r_count <= r_count - PER_W'(1);
      end
   end

endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder transmitter: emits A/B steps on command and tracks net position.
// The FSM, phase index and position counter live here; pacing comes from quad_period_timer.
module quad_encoder_gen
   import quad_gen_pkg::*;
#(
   parameter int STEP_W = 16,
   parameter int PER_W  = 16,
   parameter int POS_W  = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_dir,
   input  logic [STEP_W-1:0]       cmd_steps,
   input  logic [PER_W-1:0]        cmd_period,
   input  logic                    abort,
   input  logic                    pos_clear,
   output logic                    enc_a,
   output logic                    enc_b,
   output logic                    busy,
   output logic                    done,
   output logic signed [POS_W-1:0] position
);

   state_t              r_state;
   logic [1:0]          r_phase;
   logic                r_dir;
   logic [STEP_W-1:0]   r_remaining;
   logic [POS_W-1:0]    r_position;
   logic                r_enc_a;
   logic                r_enc_b;
   logic                r_busy;
   logic                r_done;
   logic                r_cmd_ready;

   logic [PER_W-1:0]    w_period_eff;
   logic                w_handshake;
   logic                w_tick;
   logic                w_edge;
   logic [1:0]          w_phase_next;

   assign w_period_eff = (cmd_period == '0) ? PER_W'(1) : cmd_period;
   assign w_handshake  = cmd_valid && r_cmd_ready;
   // An abort in the same cycle as a timer tick suppresses that edge.
   assign w_edge       = (r_state == ST_RUN) && w_tick && !abort;
   assign w_phase_next = (r_dir == DIR_CCW) ? r_phase - 2'd1 : r_phase + 2'd1;

   quad_period_timer #(
      .PER_W (PER_W)
   ) u_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (w_handshake),
      .load_value (w_period_eff - PER_W'(1)),
      .enable     (r_state == ST_RUN),
      .tick       (w_tick)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_phase     <= 2'd0;
         r_dir       <= DIR_CW;
         r_remaining <= '0;
         r_position  <= '0;
         r_enc_a     <= 1'b0;
         r_enc_b     <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_cmd_ready <= 1'b1;
      end else begin
         r_done <= 1'b0;

         // Clear beats a coincident edge: the edge still shows on A/B but is not counted.
         if (pos_clear)
            r_position <= '0;
         else if (w_edge)
            r_position <= (r_dir == DIR_CW) ? r_position + POS_W'(1) : r_position - POS_W'(1);

         if (w_edge) begin
            r_phase                <= w_phase_next;
            {r_enc_a, r_enc_b}     <= AB_LUT[w_phase_next];
            r_remaining            <= r_remaining - STEP_W'(1);
         end

         unique case (r_state)
            ST_IDLE: begin
               if (w_handshake) begin
                  r_dir       <= cmd_dir;
                  r_remaining <= cmd_steps;
                  r_cmd_ready <= 1'b0;
                  if (cmd_steps == '0) begin
                     r_state <= ST_FINISH;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= ST_RUN;
                     r_busy  <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (abort) begin
                  r_state     <= ST_IDLE;
                  r_busy      <= 1'b0;
                  r_cmd_ready <= 1'b1;
               end else if (w_edge && (r_remaining == STEP_W'(1))) begin
                  r_state <= ST_FINISH;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            ST_FINISH: begin
               r_state     <= ST_IDLE;
               r_cmd_ready <= 1'b1;
            end
            default: begin
               r_state     <= ST_IDLE;
               r_busy      <= 1'b0;
               r_cmd_ready <= 1'b1;
            end
         endcase
      end
   end

   assign cmd_ready = r_cmd_ready;
   assign enc_a     = r_enc_a;
   assign enc_b     = r_enc_b;
   assign busy      = r_busy;
   assign done      = r_done;
   assign position  = r_position;

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Scoreboard bench for quad_encoder_gen: the driver predicts every A/B edge and done pulse
// from step/period arithmetic; a negedge monitor pops and compares as the DUT produces them.
module tb_quad_encoder_gen;

   localparam int STEP_W = 16;
   localparam int PER_W  = 16;
   localparam int POS_W  = 16;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic              cmd_dir = 1'b0;
   logic [STEP_W-1:0] cmd_steps = '0;
   logic [PER_W-1:0]  cmd_period = '0;
   logic              abort = 1'b0;
   logic              pos_clear = 1'b0;
   logic              enc_a;
   logic              enc_b;
   logic              busy;
   logic              done;
   logic [POS_W-1:0]  position;

   always #5 clk = ~clk;

   quad_encoder_gen #(
      .STEP_W (STEP_W),
      .PER_W  (PER_W),
      .POS_W  (POS_W)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_dir    (cmd_dir),
      .cmd_steps  (cmd_steps),
      .cmd_period (cmd_period),
      .abort      (abort),
      .pos_clear  (pos_clear),
      .enc_a      (enc_a),
      .enc_b      (enc_b),
      .busy       (busy),
      .done       (done),
      .position   (position)
   );

   typedef struct {
      bit          is_done;
      int          cyc;
      logic [1:0]  ab;
      logic [15:0] pos;
   } ev_t;

   ev_t        sb_q[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc     = 0;
   bit         rst_at_edge = 1'b0;
   bit         mon_en  = 1'b0;
   int         busy_lo = 0;
   int         busy_hi = 0;
   int         rdy_hi  = 0;
   int         midx    = 0;
   int         mpos    = 0;
   logic [1:0] prev_ab = 2'b00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Gray sequence 00,10,11,01: A is high in phases 1 and 2, B in phases 2 and 3.
   function automatic logic [1:0] ab_of(input int i);
      return {(i == 1) || (i == 2), i >= 2};
   endfunction

   always @(posedge clk) begin
      cyc++;
      rst_at_edge = !reset_n;
   end

   always @(negedge clk) begin : monitor
      ev_t        ev;
      logic [1:0] ab_now;
      bit         exp_busy;
      bit         exp_rdy;
      ab_now = {enc_a, enc_b};
      if (rst_at_edge) begin
         mon_en = 1'b1;
         check("rst_ab", 32'(ab_now), 32'd0);
         check("rst_busy", 32'(busy), 32'd0);
         check("rst_done", 32'(done), 32'd0);
         check("rst_pos", 32'(position), 32'd0);
         check("rst_ready", 32'(cmd_ready), 32'd1);
      end else if (mon_en) begin
         while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL missed_event at cycle %0d: no %s seen, expected at cycle %0d",
                     cyc, sb_q[0].is_done ? "done" : "edge", sb_q[0].cyc);
            void'(sb_q.pop_front());
         end
         if (ab_now !== prev_ab) begin
            if (sb_q.size() == 0 || sb_q[0].is_done) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_edge at cycle %0d: AB %b -> %b", cyc, prev_ab, ab_now);
            end else begin
               ev = sb_q.pop_front();
               check("edge_cycle", 32'(cyc), 32'(ev.cyc));
               check("edge_ab", 32'(ab_now), 32'(ev.ab));
               check("edge_pos", 32'(position), 32'(ev.pos));
            end
         end
         if (done !== 1'b0) begin
            if (sb_q.size() == 0 || !sb_q[0].is_done) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_done at cycle %0d: done=%b", cyc, done);
            end else begin
               ev = sb_q.pop_front();
               check("done_cycle", 32'(cyc), 32'(ev.cyc));
               check("done_ab", 32'(ab_now), 32'(ev.ab));
               check("done_pos", 32'(position), 32'(ev.pos));
            end
         end
         exp_busy = (cyc >= busy_lo) && (cyc < busy_hi);
         exp_rdy  = !((cyc >= busy_lo) && (cyc < rdy_hi));
         check("busy", 32'(busy), 32'(exp_busy));
         check("cmd_ready", 32'(cmd_ready), 32'(exp_rdy));
      end
      prev_ab = ab_now;
   end

   // Offsets are cycles after the handshake edge; 0 disables that event.
   task automatic run_cmd(input bit dir, input int steps, input int period,
                          input int abort_off, input int clear_k, input int rst_off);
      int  peff;
      int  t0;
      int  t_stop;
      int  t_rdy;
      int  clear_cyc;
      ev_t ev;
      peff      = (period == 0) ? 1 : period;
      t0        = cyc + 1;
      t_stop    = 0;
      if (abort_off > 0) t_stop = t0 + abort_off;
      if (rst_off > 0)   t_stop = t0 + rst_off;
      clear_cyc = (clear_k > 0) ? t0 + clear_k * peff : 0;
      for (int k = 1; k <= steps; k++) begin
         if (t_stop != 0 && t0 + k * peff >= t_stop) break;
         midx = (midx + (dir ? 3 : 1)) % 4;
         mpos = (k == clear_k) ? 0 : ((mpos + (dir ? 65535 : 1)) & 65535);
         ev.is_done = 1'b0;
         ev.cyc     = t0 + k * peff;
         ev.ab      = ab_of(midx);
         ev.pos     = mpos[15:0];
         sb_q.push_back(ev);
      end
      if (t_stop != 0) begin
         busy_hi = t_stop;
         rdy_hi  = t_stop;
      end else begin
         ev.is_done = 1'b1;
         ev.cyc     = t0 + steps * peff;
         ev.ab      = ab_of(midx);
         ev.pos     = mpos[15:0];
         sb_q.push_back(ev);
         busy_hi = t0 + steps * peff;
         rdy_hi  = busy_hi + 1;
      end
      busy_lo = t0;
      t_rdy   = rdy_hi;
      if (rst_off > 0) begin
         midx = 0;
         mpos = 0;
      end
      cmd_dir    = dir;
      cmd_steps  = STEP_W'(steps);
      cmd_period = PER_W'(period);
      cmd_valid  = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      while (cyc < t_rdy) begin
         abort      = (abort_off > 0) && (cyc + 1 == t_stop);
         pos_clear  = (clear_cyc != 0) && (cyc + 1 == clear_cyc);
         reset_n    = !((rst_off > 0) && (cyc + 1 == t_stop));
         cmd_valid  = 1'($urandom_range(0, 1));
         cmd_dir    = 1'($urandom_range(0, 1));
         cmd_steps  = STEP_W'($urandom);
         cmd_period = PER_W'($urandom_range(0, 7));
         @(negedge clk);
      end
      abort     = 1'b0;
      pos_clear = 1'b0;
      reset_n   = 1'b1;
      cmd_valid = 1'b0;
   endtask

   task automatic clear_pos();
      pos_clear = 1'b1;
      @(negedge clk);
      pos_clear = 1'b0;
      mpos = 0;
      check("clear_pos", 32'(position), 32'd0);
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      midx = 0;
      mpos = 0;
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog at cycle %0d: bench did not finish", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin : driver
      bit dir;
      int steps;
      int per;
      int peff;
      int ab_off;
      int ck;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // CW 4 steps, period 3: 10,11,01,00 at +3,+6,+9,+12.
      run_cmd(1'b0, 4, 3, 0, 0, 0);
      check("cw4_pos", 32'(position), 32'd4);
      check("cw4_ab", 32'({enc_a, enc_b}), 32'd0);

      // CCW 2 steps, period 0 behaves as 1: 01 then 11.
      clear_pos();
      run_cmd(1'b1, 2, 0, 0, 0, 0);
      check("ccw2_pos", 32'(position), 32'h0000_FFFE);
      check("ccw2_ab", 32'({enc_a, enc_b}), 32'd3);

      // Zero-step command: done only, nothing moves.
      run_cmd(1'b0, 0, 5, 0, 0, 0);
      check("zero_pos", 32'(position), 32'h0000_FFFE);

      // Abort one cycle after the 3rd edge of a period-2 run.
      pulse_reset();
      run_cmd(1'b0, 10, 2, 7, 0, 0);
      check("abort_pos", 32'(position), 32'd3);
      check("abort_ab", 32'({enc_a, enc_b}), 32'd1);

      // Position wraps from 0x7FFF to 0x8000.
      clear_pos();
      run_cmd(1'b0, 32767, 0, 0, 0, 0);
      check("pre_wrap_pos", 32'(position), 32'h0000_7FFF);
      run_cmd(1'b0, 1, 1, 0, 0, 0);
      check("wrap_pos", 32'(position), 32'h0000_8000);

      // pos_clear coinciding with the 2nd edge.
      run_cmd(1'b0, 5, 3, 0, 2, 0);
      check("clear_edge_pos", 32'(position), 32'd3);

      // Reset one cycle after the 2nd edge, then restart from phase 0.
      run_cmd(1'b0, 8, 4, 0, 0, 9);
      run_cmd(1'b0, 2, 1, 0, 0, 0);
      check("restart_ab", 32'({enc_a, enc_b}), 32'd3);
      check("restart_pos", 32'(position), 32'd2);

      for (int n = 0; n < 40; n++) begin
         dir    = 1'($urandom_range(0, 1));
         steps  = $urandom_range(0, 12);
         per    = $urandom_range(0, 4);
         peff   = (per == 0) ? 1 : per;
         ab_off = 0;
         ck     = 0;
         if (steps > 0 && $urandom_range(0, 3) == 0) ab_off = $urandom_range(1, steps * peff);
         if (steps > 0 && $urandom_range(0, 3) == 0) ck = $urandom_range(1, steps);
         if (ab_off != 0 && ck * peff >= ab_off) ck = 0;
         run_cmd(dir, steps, per, ab_off, ck, 0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (5) @(negedge clk);
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
